dram_port_arbiter: RTL

//  Shares the single-port data RAM between the CPU load/store path and the UART monitor.

---
 rtl/dram_port_arbiter_pkg.sv | 14 +
 rtl/dram_port_arbiter_sat_counter.sv | 24 ++
 rtl/dram_port_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dram_port_arbiter_pkg.sv
// Shared types and widths for the data-RAM port arbiter.
package dram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnCpu  = 2'd1,
    OwnMon  = 2'd2
  } rd_owner_e;

  localparam int unsigned ConflictCntW = 16;
  localparam int unsigned ForcedCntW   = 8;
  localparam int unsigned WaitCntW     = 8;

endpackage

// File: rtl/dram_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear.
module dram_port_arbiter_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dram_port_arbiter.sv
// Request/grant scheduler sharing the single-port data RAM between the CPU and the UART
// monitor, with owner-tagged read returns and contention counters.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int unsigned DWIDTH   = 12,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_run,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [DWIDTH-1:0] i_cpu_adr,
  input  logic [31:0]       i_cpu_wdata,
  input  logic [3:0]        i_cpu_wstrb,
  output logic              o_cpu_gnt,
  output logic              o_cpu_rvalid,
  input  logic              i_mon_req,
  input  logic              i_mon_we,
  input  logic [DWIDTH-1:0] i_mon_adr,
  input  logic [31:0]       i_mon_wdata,
  output logic              o_mon_gnt,
  output logic              o_mon_rvalid,
  output logic [31:0]       o_rdata,
  output logic [DWIDTH-1:0] o_ram_adr,
  output logic [31:0]       o_ram_wdata,
  output logic [3:0]        o_ram_wstrb,
  output logic              o_ram_wen,
  input  logic [31:0]       i_ram_rdata,
  output logic [15:0]       o_conflict_cnt,
  output logic [7:0]        o_forced_cnt
);

  localparam logic [WaitCntW-1:0] MaxWait = WaitCntW'(MAX_WAIT);

  rd_owner_e           r_rd_owner;
  logic [WaitCntW-1:0] w_wait_cnt;
  logic                w_forced;
  logic                w_mon_gnt;
  logic                w_cpu_gnt;
  logic                w_wait_clr;
  logic                w_wait_inc;

  // Starvation guard only matters while the CPU actually competes for the port.
  assign w_forced = i_cpu_run & i_cpu_req & i_mon_req & (w_wait_cnt == MaxWait);

  assign w_mon_gnt = ~i_rst & i_mon_req & (~i_cpu_run | ~i_cpu_req | w_forced);
  assign w_cpu_gnt = ~i_rst & i_cpu_req & ~w_mon_gnt;

  assign o_mon_gnt = w_mon_gnt;
  assign o_cpu_gnt = w_cpu_gnt;

  always_comb begin
    o_ram_adr   = '0;
    o_ram_wdata = '0;
    o_ram_wstrb = '0;
    o_ram_wen   = 1'b0;
    if (w_cpu_gnt) begin
      o_ram_adr   = i_cpu_adr;
      o_ram_wdata = i_cpu_wdata;
      o_ram_wstrb = i_cpu_we ? i_cpu_wstrb : 4'h0;
      o_ram_wen   = i_cpu_we;
    end else if (w_mon_gnt) begin
      o_ram_adr   = i_mon_adr;
      o_ram_wdata = i_mon_wdata;
      o_ram_wstrb = i_mon_we ? 4'hf : 4'h0;
      o_ram_wen   = i_mon_we;
    end
  end

  // Tag of the read issued last cycle; the RAM returns its data this cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_owner <= OwnNone;
    end else if (w_cpu_gnt && !i_cpu_we) begin
      r_rd_owner <= OwnCpu;
    end else if (w_mon_gnt && !i_mon_we) begin
      r_rd_owner <= OwnMon;
    end else begin
      r_rd_owner <= OwnNone;
    end
  end

  // Reset discards an in-flight read, including its return in the reset cycle.
  assign o_cpu_rvalid = ~i_rst & (r_rd_owner == OwnCpu);
  assign o_mon_rvalid = ~i_rst & (r_rd_owner == OwnMon);
  assign o_rdata      = (o_cpu_rvalid | o_mon_rvalid) ? i_ram_rdata : 32'h0;

  assign w_wait_inc = i_mon_req & ~w_mon_gnt;
  assign w_wait_clr = ~i_mon_req | w_mon_gnt | ~i_cpu_run;

  dram_port_arbiter_sat_counter #(
    .WIDTH (WaitCntW)
  ) u_wait_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_wait_clr),
    .i_inc (w_wait_inc),
    .o_cnt (w_wait_cnt)
  );

  dram_port_arbiter_sat_counter #(
    .WIDTH (ConflictCntW)
  ) u_conflict_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (1'b0),
    .i_inc (i_cpu_req & i_mon_req),
    .o_cnt (o_conflict_cnt)
  );

  dram_port_arbiter_sat_counter #(
    .WIDTH (ForcedCntW)
  ) u_forced_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (1'b0),
    .i_inc (w_forced & ~i_rst),
    .o_cnt (o_forced_cnt)
  );

endmodule
